// File: rtl/conv_pe_array_seq_pkg.sv
// Shared types, lane geometry and the requantise/saturate helper for conv_pe_array_seq.
// Optional build macro RELU_EN: clamp negative requantised results to zero.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_QUANT,
    ST_DONE
  } state_t;

  localparam int LANES    = 4;
  localparam int DATA_W   = 8;
  localparam int WORD_W   = LANES * DATA_W;
  localparam int REQ_IN_W = 64;

  // Floor shift, saturate to int8, optionally rectify.
  function automatic logic signed [DATA_W-1:0] requant(
    input logic signed [REQ_IN_W-1:0] acc,
    input logic        [4:0]          sh
  );
    logic signed [REQ_IN_W-1:0] r;
    logic signed [DATA_W-1:0]   q;
    r = acc >>> sh;
    if (r > 64'sd127)       q = 8'sd127;
    else if (r < -64'sd128) q = -8'sd128;
    else                    q = r[DATA_W-1:0];
`ifdef RELU_EN
    if (q < 0) q = '0;
`else
    q = q;
`endif
    return q;
  endfunction

endpackage

// File: rtl/conv_pe_array_seq_if.sv
// Load / start-config / result-drain bundle for conv_pe_array_seq.
interface conv_pe_array_seq_if #(
  parameter int NUM_PE = 16,
  parameter int AW     = 7
);
  logic                  wr_en;
  logic [5:0]            wr_sel;
  logic [AW-1:0]         wr_addr;
  logic [31:0]           wr_data;
  logic                  start;
  logic [AW-1:0]         rd_base;
  logic [AW:0]           len;
  logic [4:0]            shift;
  logic [NUM_PE-1:0]     pe_en;
  logic                  busy;
  logic                  ofm_valid;
  logic                  ofm_ready;
  logic [8*NUM_PE-1:0]   ofm;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start, rd_base, len, shift, pe_en, ofm_ready,
    input  busy, ofm_valid, ofm
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start, rd_base, len, shift, pe_en, ofm_ready,
    output busy, ofm_valid, ofm
  );
endinterface

// File: rtl/conv_pe_array_seq_mac.sv
// One processing element: 4-lane int8 dot product, wrapping accumulator, requant register.
module conv_pe_mac
  import conv_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_i,
  input  logic                     vld_p1_i,
  input  logic                     en_i,
  input  logic                     quant_i,
  input  logic [4:0]               shift_i,
  input  logic [WORD_W-1:0]        ifm_p1_i,
  input  logic [WORD_W-1:0]        wgt_p1_i,
  output logic signed [DATA_W-1:0] ofm_o
);
  localparam int SUM_W = 2 * DATA_W + $clog2(LANES);

  logic signed [DATA_W-1:0]   a;
  logic signed [DATA_W-1:0]   b;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [SUM_W-1:0]    dot_p1;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [DATA_W-1:0]   ofm_q;

  // Stage p1 -> accumulator: read data arrives one cycle after its address.
  always_comb begin
    a      = '0;
    b      = '0;
    prod   = '0;
    dot_p1 = '0;
    for (int k = 0; k < LANES; k++) begin
      a      = ifm_p1_i[k*DATA_W +: DATA_W];
      b      = wgt_p1_i[k*DATA_W +: DATA_W];
      prod   = a * b;
      dot_p1 = dot_p1 + SUM_W'(prod);
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (clr_i)                 acc_d = '0;
    else if (vld_p1_i && en_i) acc_d = acc_q + ACC_W'(dot_p1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      ofm_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (quant_i) ofm_q <= en_i ? requant(REQ_IN_W'(acc_q), shift_i) : '0;
    end
  end

  assign ofm_o = ofm_q;

endmodule

// File: rtl/conv_pe_array_seq.sv
// Sequenced IFM x NUM_PE weight-bank convolution array with valid/ready result drain.
// Optional build macro RELU_EN (see conv_pkg::requant).
module conv_pe_array_seq
  import conv_pkg::*;
#(
  parameter int NUM_PE = 16,
  parameter int DEPTH  = 128,
  parameter int ACC_W  = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  conv_pe_array_seq_if.slave bus
);
  state_t                  state_q;
  logic [AW-1:0]           base_q;
  logic [AW:0]             len_q;
  logic [AW:0]             cnt_q;
  logic [4:0]              shift_q;
  logic [NUM_PE-1:0]       pe_en_q;
  logic                    busy_q;
  logic                    valid_q;
  logic                    vld_p1;
  logic [AW-1:0]           rd_addr;
  logic                    wr_ok;
  logic                    start_ok;
  logic                    quant;
  logic [WORD_W-1:0]       ifm_mem [DEPTH];
  logic [WORD_W-1:0]       ifm_p1;
  logic [NUM_PE*DATA_W-1:0] ofm_w;

  // Address wraps naturally modulo DEPTH through the AW-bit add.
  assign rd_addr  = base_q + cnt_q[AW-1:0];
  assign wr_ok    = bus.wr_en && (state_q == ST_IDLE);
  assign start_ok = bus.start && (state_q == ST_IDLE);
  assign quant    = (state_q == ST_QUANT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      pe_en_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            base_q  <= bus.rd_base;
            len_q   <= bus.len;
            shift_q <= bus.shift;
            pe_en_q <= bus.pe_en;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= (bus.len == '0) ? ST_QUANT : ST_FETCH;
          end
        end
        ST_FETCH: begin
          cnt_q <= cnt_q + (AW+1)'(1);
          if (cnt_q == len_q - (AW+1)'(1)) state_q <= ST_DRAIN;
        end
        ST_DRAIN: state_q <= ST_QUANT;
        ST_QUANT: begin
          state_q <= ST_DONE;
          valid_q <= 1'b1;
        end
        ST_DONE: begin
          if (bus.ofm_ready) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Stage p0 -> p1: address issued in FETCH, data and its valid one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= (state_q == ST_FETCH);
  end

  always_ff @(posedge clk) begin
    if (wr_ok && bus.wr_sel == 6'd0) ifm_mem[bus.wr_addr] <= bus.wr_data;
    ifm_p1 <= ifm_mem[rd_addr];
  end

  for (genvar p = 0; p < NUM_PE; p++) begin : g_pe
    logic [WORD_W-1:0] w_mem [DEPTH];
    logic [WORD_W-1:0] w_p1;

    always_ff @(posedge clk) begin
      if (wr_ok && bus.wr_sel == 6'(p + 1)) w_mem[bus.wr_addr] <= bus.wr_data;
      w_p1 <= w_mem[rd_addr];
    end

    conv_pe_mac #(.ACC_W(ACC_W)) u_mac (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (start_ok),
      .vld_p1_i (vld_p1),
      .en_i     (pe_en_q[p]),
      .quant_i  (quant),
      .shift_i  (shift_q),
      .ifm_p1_i (ifm_p1),
      .wgt_p1_i (w_p1),
      .ofm_o    (ofm_w[p*DATA_W +: DATA_W])
    );
  end

  assign bus.ofm       = ofm_w;
  assign bus.busy      = busy_q;
  assign bus.ofm_valid = valid_q;

endmodule

// File: tb/tb_conv_pe_array_seq.sv
// Randomised self-checking bench for conv_pe_array_seq against a plain-arithmetic bank model.
module tb_conv_pe_array_seq;
  localparam int NPE = 16;
  localparam int DEP = 128;
  localparam int AWL = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_pe_array_seq_if #(.NUM_PE(NPE), .AW(AWL)) bus ();

  conv_pe_array_seq #(.NUM_PE(NPE), .DEPTH(DEP), .ACC_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] ifm_m [DEP];
  logic [31:0] w_m   [NPE][DEP];

  function automatic logic [8*NPE-1:0] model(input int base, input int len, input int sh,
                                             input logic [NPE-1:0] en);
    logic [8*NPE-1:0] res;
    longint acc;
    longint r;
    int a;
    res = '0;
    for (int p = 0; p < NPE; p++) begin
      if (en[p]) begin
        acc = 0;
        for (int i = 0; i < len; i++) begin
          a = (base + i) % DEP;
          for (int k = 0; k < 4; k++)
            acc += longint'(byte'(ifm_m[a] >> (8*k))) * longint'(byte'(w_m[p][a] >> (8*k)));
        end
        acc = longint'(int'(acc));
        r = acc >>> sh;
        if (r > 127) r = 127;
        else if (r < -128) r = -128;
`ifdef RELU_EN
        if (r < 0) r = 0;
`endif
        res[8*p +: 8] = 8'(r);
      end
    end
    return res;
  endfunction

  task automatic wr(input int sel, input int addr, input logic [31:0] d, input bit upd);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = 6'(sel);
    bus.wr_addr = 7'(addr);
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (upd) begin
      if (sel == 0) ifm_m[addr] = d;
      else          w_m[sel-1][addr] = d;
    end
  endtask

  task automatic compute(input int base, input int len, input int sh, input logic [NPE-1:0] en,
                         input int hold, output int lat, output logic busy_after,
                         output logic [8*NPE-1:0] res, output bit stable,
                         output logic done_busy, output logic done_valid);
    bus.start   = 1'b1;
    bus.rd_base = 7'(base);
    bus.len     = 8'(len);
    bus.shift   = 5'(sh);
    bus.pe_en   = en;
    @(negedge clk);
    bus.start  = 1'b0;
    busy_after = bus.busy;
    lat = 1;
    while (bus.ofm_valid !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    res    = bus.ofm;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.ofm !== res || bus.ofm_valid !== 1'b1 || bus.busy !== 1'b1) stable = 1'b0;
    end
    bus.ofm_ready = 1'b1;
    @(negedge clk);
    bus.ofm_ready = 1'b0;
    done_busy  = bus.busy;
    done_valid = bus.ofm_valid;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.ofm_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.ofm_valid); end
    checks++; if (bus.ofm !== '0) begin failures++; $display("FAIL reset_ofm got=%h exp=0", bus.ofm); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic init_banks();
    for (int s = 0; s <= NPE; s++)
      for (int a = 0; a < DEP; a++) wr(s, a, $urandom, 1'b1);
  endtask

  task automatic test_basic();
    int lat; logic ba, db, dv; logic [8*NPE-1:0] res, exp; bit st;
    for (int a = 0; a < 4; a++) wr(0, a, 32'h01010101, 1'b1);
    for (int a = 0; a < 4; a++) wr(1, a, 32'h02020202, 1'b1);
    exp = model(0, 4, 0, '1);
    compute(0, 4, 0, '1, 0, lat, ba, res, st, db, dv);
    checks++; if (res[7:0] !== 8'd32) begin failures++; $display("FAIL basic_pe0 got=%0d exp=32", res[7:0]); end
    checks++; if (res !== exp) begin failures++; $display("FAIL basic_ofm got=%h exp=%h", res, exp); end
    checks++; if (lat !== 7) begin failures++; $display("FAIL basic_latency got=%0d exp=7", lat); end
    checks++; if (ba !== 1'b1) begin failures++; $display("FAIL basic_busy_rise got=%b exp=1", ba); end
    checks++; if (db !== 1'b0 || dv !== 1'b0) begin failures++; $display("FAIL basic_after_hs busy=%b valid=%b exp=0/0", db, dv); end
  endtask

  task automatic test_saturate();
    int lat; logic ba, db, dv; logic [8*NPE-1:0] res, exp; bit st; logic [7:0] neg_exp;
    for (int a = 0; a < DEP; a++) wr(0, a, 32'h7f7f7f7f, 1'b1);
    for (int a = 0; a < DEP; a++) wr(1, a, 32'h7f7f7f7f, 1'b1);
    exp = model(0, 128, 0, '1);
    compute(0, 128, 0, '1, 0, lat, ba, res, st, db, dv);
    checks++; if (res[7:0] !== 8'd127) begin failures++; $display("FAIL sat_pos got=%h exp=7f", res[7:0]); end
    checks++; if (res !== exp) begin failures++; $display("FAIL sat_pos_ofm got=%h exp=%h", res, exp); end
    checks++; if (lat !== 131) begin failures++; $display("FAIL sat_latency got=%0d exp=131", lat); end
    for (int a = 0; a < DEP; a++) wr(1, a, 32'h80808080, 1'b1);
`ifdef RELU_EN
    neg_exp = 8'h00;
`else
    neg_exp = 8'h80;
`endif
    exp = model(0, 128, 0, '1);
    compute(0, 128, 0, '1, 0, lat, ba, res, st, db, dv);
    checks++; if (res[7:0] !== neg_exp) begin failures++; $display("FAIL sat_neg got=%h exp=%h", res[7:0], neg_exp); end
    checks++; if (res !== exp) begin failures++; $display("FAIL sat_neg_ofm got=%h exp=%h", res, exp); end
    for (int a = 0; a < DEP; a++) wr(0, a, $urandom, 1'b1);
    for (int a = 0; a < DEP; a++) wr(1, a, $urandom, 1'b1);
  endtask

  task automatic test_wrap();
    int lat, sh; logic ba, db, dv; logic [8*NPE-1:0] res, exp; bit st;
    sh  = $urandom_range(0, 6);
    exp = model(126, 4, sh, '1);
    compute(126, 4, sh, '1, 0, lat, ba, res, st, db, dv);
    checks++; if (res !== exp) begin failures++; $display("FAIL wrap_ofm got=%h exp=%h", res, exp); end
    checks++; if (lat !== 7) begin failures++; $display("FAIL wrap_latency got=%0d exp=7", lat); end
  endtask

  task automatic test_pe_en_hold();
    int lat; logic ba, db, dv; logic [8*NPE-1:0] res, exp; bit st;
    exp = model(10, 20, 2, 16'h0001);
    compute(10, 20, 2, 16'h0001, 10, lat, ba, res, st, db, dv);
    checks++; if (res !== exp) begin failures++; $display("FAIL pe_en_ofm got=%h exp=%h", res, exp); end
    checks++; if (res[8*NPE-1:8] !== '0) begin failures++; $display("FAIL pe_en_disabled got=%h exp=0", res[8*NPE-1:8]); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL hold_stable got=%b exp=1", st); end
    checks++; if (db !== 1'b0) begin failures++; $display("FAIL hold_busy_fall got=%b exp=0", db); end
  endtask

  task automatic test_len0_busy_write();
    int lat; logic ba, db, dv; logic [8*NPE-1:0] res, exp; bit st; logic [31:0] nv;
    compute(0, 0, 0, '1, 0, lat, ba, res, st, db, dv);
    checks++; if (res !== '0) begin failures++; $display("FAIL len0_ofm got=%h exp=0", res); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL len0_latency got=%0d exp=2", lat); end
    nv = ~ifm_m[5];
    fork
      compute(0, 8, 0, '1, 0, lat, ba, res, st, db, dv);
      begin
        @(negedge clk); @(negedge clk);
        wr(0, 5, nv, 1'b0);
        wr(1, 5, ~w_m[0][5], 1'b0);
      end
    join
    exp = model(5, 1, 0, '1);
    compute(5, 1, 0, '1, 0, lat, ba, res, st, db, dv);
    checks++; if (res !== exp) begin failures++; $display("FAIL busy_write_dropped got=%h exp=%h", res, exp); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL len1_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_reset_mid();
    int lat, base; logic ba, db, dv; logic [8*NPE-1:0] res, exp; bit st;
    compute(0, 16, 0, '1, 0, lat, ba, res, st, db, dv);
    bus.start = 1'b1; bus.rd_base = 7'd3; bus.len = 8'd100; bus.shift = 5'd0; bus.pe_en = '1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.ofm_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", bus.ofm_valid); end
    checks++; if (bus.ofm !== '0) begin failures++; $display("FAIL rst_mid_ofm got=%h exp=0", bus.ofm); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    base = $urandom_range(0, DEP-1);
    exp  = model(base, 40, 3, '1);
    compute(base, 40, 3, '1, 0, lat, ba, res, st, db, dv);
    checks++; if (res !== exp) begin failures++; $display("FAIL post_rst_ofm got=%h exp=%h", res, exp); end
    checks++; if (lat !== 43) begin failures++; $display("FAIL post_rst_latency got=%0d exp=43", lat); end
  endtask

  task automatic test_back_to_back();
    int lat, base, len, sh; logic ba, db, dv; logic [8*NPE-1:0] res, exp; logic [NPE-1:0] en; bit st;
    for (int n = 0; n < 8; n++) begin
      base = $urandom_range(0, DEP-1);
      len  = (n == 0) ? DEP : $urandom_range(1, DEP);
      sh   = $urandom_range(0, 12);
      en   = NPE'($urandom);
      exp  = model(base, len, sh, en);
      compute(base, len, sh, en, $urandom_range(0, 3), lat, ba, res, st, db, dv);
      checks++; if (res !== exp) begin failures++; $display("FAIL b2b_ofm[%0d] got=%h exp=%h", n, res, exp); end
      checks++; if (lat !== len + 3) begin failures++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", n, lat, len + 3); end
      checks++; if (st !== 1'b1 || db !== 1'b0) begin failures++; $display("FAIL b2b_hs[%0d] stable=%b busy=%b exp=1/0", n, st, db); end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.wr_en = 1'b0; bus.wr_sel = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.rd_base = '0; bus.len = '0; bus.shift = '0; bus.pe_en = '0;
    bus.ofm_ready = 1'b0;
    test_reset();
    init_banks();
    test_basic();
    test_saturate();
    test_wrap();
    test_pe_en_hold();
    test_len0_busy_write();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
